// File: rtl/des_pkg.sv
// DES constant tables, widths, state type and permutation helpers for the IP/key-schedule front end.
// DES_DECRYPT_EN additionally provides the right-rotation helper used by the reverse schedule.
package des_pkg;

    localparam int unsigned HALF_W   = 32;
    localparam int unsigned CD_W     = 28;
    localparam int unsigned SUBKEY_W = 48;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    // Tables use FIPS 46-3 bit numbering (1-based, MSB first).
    localparam logic [6:0] IP_TBL [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] PC1_TBL [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] b);
        logic [63:0] o;
        o = '0;
        for (int unsigned j = 0; j < 64; j++)
            o[6'(63 - j)] = b[6'(64 - IP_TBL[j])];
        return o;
    endfunction

    function automatic logic [2*CD_W-1:0] pc1_perm(input logic [63:0] k);
        logic [2*CD_W-1:0] o;
        o = '0;
        for (int unsigned j = 0; j < 2*CD_W; j++)
            o[6'(2*CD_W - 1 - j)] = k[6'(64 - PC1_TBL[j])];
        return o;
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction
`endif

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit C||D register pair to a 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   cd,
    output logic [SUBKEY_W-1:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int unsigned j = 0; j < SUBKEY_W; j++)
            subkey[6'(SUBKEY_W - 1 - j)] = cd[6'(2*CD_W - PC2_TBL[j])];
    end

endmodule

// File: rtl/des_ip_keysched.sv
// DES front end: initial permutation of the block and a 16-subkey stream over valid/ready.
// Define DES_DECRYPT_EN to add in_decrypt and the reverse K16..K1 schedule.
module des_ip_keysched
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_block,
    input  logic [63:0]         in_key,
`ifdef DES_DECRYPT_EN
    input  logic                in_decrypt,
`endif
    output logic [HALF_W-1:0]   out_l0,
    output logic [HALF_W-1:0]   out_r0,
    output logic                out_start,
    output logic                sk_valid,
    input  logic                sk_ready,
    output logic [SUBKEY_W-1:0] sk_data,
    output logic [3:0]          sk_round,
    output logic                sk_last,
    output logic                busy
);

    state_t            state;
    logic              rdy_q;
    logic [3:0]        cnt;
    logic [CD_W-1:0]   c_q, d_q;
    logic [CD_W-1:0]   c0, d0;
    logic [CD_W-1:0]   c_step, d_step;
    logic [CD_W-1:0]   c_init, d_init;
    logic [2*CD_W-1:0] cd0;
    logic [63:0]       ip_blk;
    logic              accept;
    logic              hs;

    assign ip_blk   = ip_perm(in_block);
    assign cd0      = pc1_perm(in_key);
    assign c0       = cd0[2*CD_W-1:CD_W];
    assign d0       = cd0[CD_W-1:0];

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_q && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ROUND);
    assign sk_valid = busy;
    assign hs       = sk_valid && sk_ready;
    assign sk_last  = busy && (cnt == 4'd15);

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (sk_data)
    );

`ifdef DES_DECRYPT_EN
    logic dec_q;

    assign sk_round = dec_q ? (4'd15 - cnt) : cnt;

    // Decrypt starts from C0/D0 (== C16/D16) and undoes each round's shift.
    always_comb begin
        c_init = in_decrypt ? c0 : rotl28(c0, 2'd1);
        d_init = in_decrypt ? d0 : rotl28(d0, 2'd1);
        if (dec_q) begin
            c_step = rotr28(c_q, SHIFT_TBL[sk_round]);
            d_step = rotr28(d_q, SHIFT_TBL[sk_round]);
        end else begin
            c_step = rotl28(c_q, SHIFT_TBL[cnt + 4'd1]);
            d_step = rotl28(d_q, SHIFT_TBL[cnt + 4'd1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dec_q <= 1'b0;
        else if (accept)
            dec_q <= in_decrypt;
    end
`else
    assign sk_round = cnt;

    // The index wraps to 0 on the final handshake; that step is discarded.
    always_comb begin
        c_init = rotl28(c0, 2'd1);
        d_init = rotl28(d0, 2'd1);
        c_step = rotl28(c_q, SHIFT_TBL[cnt + 4'd1]);
        d_step = rotl28(d_q, SHIFT_TBL[cnt + 4'd1]);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            out_l0    <= '0;
            out_r0    <= '0;
            out_start <= 1'b0;
            cnt       <= '0;
            c_q       <= '0;
            d_q       <= '0;
        end else begin
            rdy_q     <= 1'b1;
            out_start <= accept;
            if (accept) begin
                out_l0 <= ip_blk[2*HALF_W-1:HALF_W];
                out_r0 <= ip_blk[HALF_W-1:0];
                c_q    <= c_init;
                d_q    <= d_init;
                cnt    <= '0;
                state  <= ROUND;
            end else if (hs) begin
                c_q <= c_step;
                d_q <= d_step;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_des_ip_keysched.sv
// Randomized self-checking bench for des_ip_keysched against a table-driven DES key-schedule model.
module tb_des_ip_keysched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_block = '0;
    logic [63:0] in_key = '0;
`ifdef DES_DECRYPT_EN
    logic        in_decrypt = 1'b0;
`endif
    logic [31:0] out_l0, out_r0;
    logic        out_start, sk_valid, sk_last, busy;
    logic        sk_ready = 1'b0;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t1_cyc  = 0;

    logic [31:0] cap_l0, cap_r0;
    logic [47:0] cap_first, cap_last;
    logic [3:0]  cap_first_rnd, cap_last_rnd;
    logic [47:0] m_ks [16];

    localparam logic [63:0] KAT_BLK = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

    int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                       16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                       44,49,39,56,34,53, 46,42,50,36,29,32};
    int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_ip_keysched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_key     (in_key),
`ifdef DES_DECRYPT_EN
        .in_decrypt (in_decrypt),
`endif
        .out_l0     (out_l0),
        .out_r0     (out_r0),
        .out_start  (out_start),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .sk_data    (sk_data),
        .sk_round   (sk_round),
        .sk_last    (sk_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_ip(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int j = 0; j < 64; j++)
            r |= ((x >> (64 - IP_T[j])) & 64'd1) << (63 - j);
        return r;
    endfunction

    function automatic logic [63:0] m_ip_inv(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int j = 0; j < 64; j++)
            r |= ((x >> (63 - j)) & 64'd1) << (64 - IP_T[j]);
        return r;
    endfunction

    // Subkeys from cumulative left shifts of PC-1 halves, then PC-2.
    task automatic gen_ks(input logic [63:0] key);
        logic [63:0] cd, c, d, k;
        cd = '0;
        for (int j = 0; j < 56; j++)
            cd |= ((key >> (64 - PC1_T[j])) & 64'd1) << (55 - j);
        c = (cd >> 28) & 64'hFFFFFFF;
        d = cd & 64'hFFFFFFF;
        for (int r = 0; r < 16; r++) begin
            c = ((c << SH_T[r]) | (c >> (28 - SH_T[r]))) & 64'hFFFFFFF;
            d = ((d << SH_T[r]) | (d >> (28 - SH_T[r]))) & 64'hFFFFFFF;
            cd = (c << 28) | d;
            k = '0;
            for (int j = 0; j < 48; j++)
                k |= ((cd >> (56 - PC2_T[j])) & 64'd1) << (47 - j);
            m_ks[r] = k[47:0];
        end
    endtask

    task automatic run_block(input logic [63:0] blk, input logic [63:0] key, input bit dec,
                             input bit stall, input bit keep_valid, input int abort_after);
        logic [63:0] ipv;
        logic [47:0] exp_k;
        int idx, waited, forced, e_rnd;
        gen_ks(key);
        ipv = m_ip(blk);
        in_block = blk;
        in_key   = key;
        in_valid = 1'b1;
`ifdef DES_DECRYPT_EN
        in_decrypt = dec;
`endif
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 64'(in_ready), 64'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        t1_cyc = cyc;
        check("start_pulse", 64'(out_start), 64'd1);
        check("busy_t1", 64'(busy), 64'd1);
        check("l0", 64'(out_l0), 64'(ipv[63:32]));
        check("r0", 64'(out_r0), 64'(ipv[31:0]));
        check("ip_roundtrip", m_ip_inv({out_l0, out_r0}), blk);
        cap_l0 = out_l0;
        cap_r0 = out_r0;
        in_valid = keep_valid;
        in_block = {$urandom, $urandom};
        in_key   = {$urandom, $urandom};
        idx = 0; waited = 0; forced = 0;
        while (idx < 16 && waited < 400) begin
            if (abort_after > 0 && idx == abort_after) begin
                in_valid = 1'b0;
                rst = 1'b0;
                #1;
                check("abort_sk_valid", 64'(sk_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                rst = 1'b1;
                sk_ready = 1'b0;
                return;
            end
            if (stall && idx == 5 && forced < 5) begin
                sk_ready = 1'b0;
                forced++;
            end else if (stall)
                sk_ready = ($urandom_range(0, 1) == 1);
            else
                sk_ready = 1'b1;
            exp_k = dec ? m_ks[15 - idx] : m_ks[idx];
            e_rnd = dec ? 15 - idx : idx;
            if (waited > 0)
                check("no_restart", 64'(out_start), 64'd0);
            check("sk_valid", 64'(sk_valid), 64'd1);
            check("sk_data", 64'(sk_data), 64'(exp_k));
            check("sk_round", 64'(sk_round), 64'(e_rnd));
            check("sk_last", 64'(sk_last), 64'(idx == 15));
            if (sk_ready) begin
                if (idx == 0) begin cap_first = sk_data; cap_first_rnd = sk_round; end
                if (idx == 15) begin cap_last = sk_data; cap_last_rnd = sk_round; end
                idx++;
            end
            @(negedge clk);
            waited++;
        end
        check("all_subkeys", 64'(idx), 64'd16);
        if (!stall)
            check("latency", 64'(cyc - t1_cyc), 64'd16);
        check("end_in_ready", 64'(in_ready), 64'd1);
        check("end_busy", 64'(busy), 64'd0);
        check("end_sk_valid", 64'(sk_valid), 64'd0);
    endtask

    initial begin
        int t_a;
        bit d;
        // Reset held with a block offered: nothing may be accepted.
        in_valid = 1'b1;
        in_block = KAT_BLK;
        in_key   = KAT_KEY;
        sk_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sk_valid", 64'(sk_valid), 64'd0);
        check("rst_start", 64'(out_start), 64'd0);
        check("rst_last", 64'(sk_last), 64'd0);
        check("rst_l0", 64'(out_l0), 64'd0);
        check("rst_r0", 64'(out_r0), 64'd0);
        check("rst_sk_data", 64'(sk_data), 64'd0);
        rst = 1'b1;
        #1 check("rel_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("first_edge_busy", 64'(busy), 64'd0);
        check("first_edge_ready", 64'(in_ready), 64'd1);

        run_block(KAT_BLK, KAT_KEY, 1'b0, 1'b0, 1'b0, 0);
        check("kat_l0", 64'(cap_l0), 64'hCC00CCFF);
        check("kat_r0", 64'(cap_r0), 64'hF0AAF0AA);
        check("kat_k1", 64'(cap_first), 64'h1B02EFFC7072);
        check("kat_k16", 64'(cap_last), 64'hCB3D8B0E17F5);

        run_block(KAT_BLK, KAT_KEY, 1'b0, 1'b1, 1'b0, 0);
        check("stall_k16", 64'(cap_last), 64'hCB3D8B0E17F5);

`ifdef DES_DECRYPT_EN
        run_block(KAT_BLK, KAT_KEY, 1'b1, 1'b0, 1'b0, 0);
        check("dec_first", 64'(cap_first), 64'hCB3D8B0E17F5);
        check("dec_first_rnd", 64'(cap_first_rnd), 64'd15);
        check("dec_last", 64'(cap_last), 64'h1B02EFFC7072);
        check("dec_last_rnd", 64'(cap_last_rnd), 64'd0);
        run_block(KAT_BLK, KAT_KEY, 1'b1, 1'b1, 1'b0, 0);
`endif

        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 7);
        run_block(KAT_BLK, KAT_KEY, 1'b0, 1'b0, 1'b0, 0);
        check("post_abort_k1", 64'(cap_first), 64'h1B02EFFC7072);
        check("post_abort_rnd", 64'(cap_first_rnd), 64'd0);

        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 0);
        t_a = t1_cyc;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 0);
        check("b2b_spacing", 64'(t1_cyc - t_a), 64'd17);

        for (int i = 0; i < 6; i++) begin
`ifdef DES_DECRYPT_EN
            d = ($urandom_range(0, 1) == 1);
`else
            d = 1'b0;
`endif
            run_block({$urandom, $urandom}, {$urandom, $urandom}, d,
                      ($urandom_range(0, 1) == 1), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/des_ip_keysched.md
# des_ip_keysched

Front-end of the DES datapath, on the input side opposite the inverse-initial-permutation output stage. It accepts a 64-bit block and 64-bit key through a valid/ready handshake and applies the initial permutation IP, registering L0/R0. It then streams the sixteen 48-bit round subkeys to the round core, one per handshake. The round core consumes L0/R0 plus the subkey stream; the inverse-permutation stage closes the path.

## Interface
Parameters: none; all DES tables are fixed constants.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  block/key offered
- in_ready  out  1  block can be accepted; high only in IDLE
- in_block  in  64  message block; DES bit n (1..64, FIPS 46-3 numbering) is index 64-n
- in_key  in  64  key, same numbering; parity bits 8,16,…,64 ignored
- in_decrypt  in  1  present only with DES_DECRYPT_EN; 1 = emit K16..K1
- out_l0  out  32  left half of IP(in_block), held until next acceptance
- out_r0  out  32  right half of IP(in_block), held until next acceptance
- out_start  out  1  one-cycle pulse; out_l0/out_r0 newly valid
- sk_valid  out  1  subkey on sk_data is valid
- sk_ready  in  1  round core consumes subkey
- sk_data  out  48  current subkey, PC-2 of registered C/D
- sk_round  out  4  round index of sk_data, 0..15 (K1 = 0)
- sk_last  out  1  high with the 16th subkey of a block
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ROUND.
- IDLE:
  - in_ready = 1.
  - On in_valid: register IP(in_block) into out_l0/out_r0.
  - Compute C0/D0 = PC-1(in_key), 28 bits each.
  - Encrypt: store C1/D1, each half rotated left by 1.
  - Decrypt: store C0/D0 unrotated (C16 = C0 after 28 total shifts).
  - Clear round counter, pulse out_start next cycle, go to ROUND.
- ROUND:
  - sk_valid = 1; sk_data = PC-2(C,D), combinational from registers.
  - Encrypt: sk_round = counter.
  - Decrypt: sk_round = 15 − counter.
  - On sk_valid & sk_ready:
    - counter increments.
    - Encrypt: rotate C/D left by SHIFT[counter+1].
    - Decrypt: rotate C/D right by SHIFT[sk_round].
  - SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16.
  - sk_last = 1 when counter = 15.
  - Handshake with sk_last high returns to IDLE.
- sk_ready low holds sk_data, sk_round, C/D and counter unchanged; sk_valid stays high. No subkey is dropped or duplicated.
- in_valid while busy is ignored; the upstream holds it.
- in_key/in_block are sampled only on acceptance; later changes have no effect.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - State IDLE.
  - out_l0, out_r0, sk_data, C/D, counter all 0.
  - out_start, sk_valid, sk_last, busy = 0.
  - in_ready = 0 while rst is low, 1 from the first edge after release.
- Accept at edge T. At T+1: out_start = 1, busy = 1, sk_valid = 1 with K1 (decrypt: K16).
- With sk_ready held high, subkey i appears at T+1+i. The last handshake is at T+16; IDLE and in_ready = 1 at T+17.
- Back-to-back blocks: minimum 17 cycles per block.
- Reset mid-ROUND aborts the block. sk_valid = 0 from reset assertion and no further subkeys are issued.
- sk_ready high in IDLE: no effect.

## Configuration
- DES_DECRYPT_EN defined:
  - in_decrypt port exists; the mode is latched on acceptance and held for the block.
  - Decrypt order is K16..K1 with right rotations.
- DES_DECRYPT_EN undefined:
  - Port absent; encrypt order only; right-rotate logic not built.

## Structure
- Package des_pkg holds:
  - IP (64 entries), PC1 (56), PC2 (48) index tables
  - SHIFT schedule
  - state enum {IDLE, ROUND}
  - widths HALF_W = 32, CD_W = 28, SUBKEY_W = 48
- Sub-module des_pc2: combinational 56→48 compression. It is shared with any future key-schedule user.

## Test plan
- Reset with in_valid = 1 → all outputs 0; in_ready = 0 until first edge after release; no acceptance during reset.
- Block 0123456789ABCDEF, key 133457799BBCDFF1, sk_ready = 1 → out_l0 = CC00CCFF, out_r0 = F0AAF0AA; K1 = 1B02EFFC7072 at T+1; K16 = CB3D8B0E17F5 at T+16 with sk_last = 1; in_ready at T+17.
- Same vectors, sk_ready toggled randomly (including 5-cycle stalls) → identical 16-subkey sequence; sk_data stable while stalled.
- DES_DECRYPT_EN, in_decrypt = 1, same key → first subkey CB3D8B0E17F5 with sk_round = 15; last 1B02EFFC7072 with sk_round = 0.
- Reset asserted after the 7th subkey handshake → sk_valid drops immediately. The next block restarts at K1 with correct values.
- in_valid held high across two blocks → second acceptance exactly at T+17; out_start pulses once per block; round-trip through the inverse-permutation stage returns the original block for IP-only data.
